par8_bus_rx: RTL and testbench
==============================

# par8_bus_rx

Front-end for the RPi 8-bit parallel bus, sitting between the bus pins and the downstream byte consumers (data checkers, hash loaders).
- Synchronises `bus_clk`, `bus_rnw` and `bus_data` into the 100 MHz domain and detects each rising edge of `bus_clk`.
- On a write edge (master writing), pushes the byte into a first-word-fall-through FIFO presented with valid/ready.
- On a read edge (master reading), retires a response byte loaded by the consumer through a valid/ready port.
- Reports FIFO overflow and read underrun as sticky flags.

## Interface
- `DEPTH`, 16, FIFO entries; power of two, ≥2.
- `CNT_W`, 16, width of accepted-byte counter.

- `clk_100mhz`  in  1  sole clock.
- `reset_n`  in  1  reset; synchronous, active-low.
- `bus_clk`  in  1  RPi strobe, asynchronous.
- `bus_rnw`  in  1  1 = master reads, 0 = master writes (master perspective).
- `bus_data`  inout  8  bidirectional bus data.
- `rx_data`  out  8  head-of-FIFO byte.
- `rx_valid`  out  1  FIFO not empty.
- `rx_ready`  in  1  consumer pops when `rx_valid & rx_ready`.
- `tx_data`  in  8  response byte for the master.
- `tx_valid`  in  1  response byte offered.
- `tx_ready`  out  1  holding register empty; load occurs when `tx_valid & tx_ready`.
- `rx_count`  out  CNT_W  bytes accepted into FIFO, wraps modulo 2^CNT_W.
- `overflow`  out  1  sticky: a write byte was dropped.
- `underrun`  out  1  sticky: read edge with no loaded response.

## Operation
- Sync: `bus_clk`, `bus_rnw`, `bus_data` each pass through two flops (s1→s2). `clk_prev` registers s2 of `bus_clk`. Edge = s2 & ~`clk_prev`.
- Write edge = edge & (s2 `bus_rnw` == 0). Read edge = edge & (s2 `bus_rnw` == 1).
- Write edge, push condition: push s2 `bus_data` if FIFO not full or a pop occurs the same cycle.
  - On push: increment `rx_count`.
  - Otherwise: drop the byte and set `overflow`.
- FIFO: read/write pointers log2(DEPTH)+1 bits wide. Full = MSBs differ and LSBs equal; empty = pointers equal.
- `rx_data` = mem[rd_ptr], with no extra latency.
- Simultaneous push and pop on an empty FIFO: the pop has no effect because `rx_valid` is 0; the push proceeds.
- Response path: `tx_hold` (8b) and `tx_loaded` (1b).
  - `tx_ready` = ~`tx_loaded`.
  - Load: `tx_hold` ← `tx_data`, `tx_loaded` ← 1.
  - Read edge with `tx_loaded` = 1: `tx_loaded` ← 0 (byte consumed).
  - Read edge with `tx_loaded` = 0: set `underrun`; `tx_hold` keeps its old value.
  - A load and a consume cannot coincide, since `tx_ready` is 0 whenever loaded.
- Pin drive: `bus_data` = `tx_hold` when raw pin `bus_rnw` == 1, else high-Z. This is combinational on the unsynchronised pin, so the bus turns around immediately.
- Sticky flags clear only on reset.

## Timing
- Reset (`reset_n` low at a rising clock edge) forces the following; reset mid-transfer discards FIFO contents and any loaded response:
  - all sync/prev flops 0;
  - pointers 0, so `rx_valid` = 0;
  - `rx_count` = 0, `overflow` = 0, `underrun` = 0;
  - `tx_loaded` = 0 (`tx_ready` = 1), `tx_hold` = 0x00.
- Write latency: let E1 be the first clock edge that samples `bus_clk` high.
  - s2 goes high at E2; the push happens at E3.
  - `rx_valid` / `rx_data` are visible after E3.
  - Minimum is 3 clocks, maximum 4 including sampling uncertainty.
- Master contract: `bus_data` and `bus_rnw` stable ≥ 3 clocks (30 ns) before the `bus_clk` rise and until ≥ 3 clocks after it. `bus_clk` high and low phases each ≥ 3 clocks. Violations give undefined data but must not corrupt FIFO pointers.
- Response: `tx_ready` rises on the clock after the read-edge consume cycle. The master must allow ≥ 4 clocks after its read strobe before sampling the next byte.
- One edge is counted per `bus_clk` rise, regardless of high-phase length.

## Test plan
- Reset mid-stream: push 5 bytes, pulse `reset_n` low for 1 clock → `rx_valid` = 0, `rx_count` = 0, flags 0, `tx_ready` = 1.
- Write 0x00..0xFF with `rx_ready` = 1 → consumer sees 256 bytes in order, each `rx_valid` 3–4 clocks after its `bus_clk` rise, `rx_count` = 256, `overflow` = 0.
- DEPTH = 16, `rx_ready` = 0, write 0x10..0x20 (17 bytes) → 16 entries 0x10..0x1F held, 0x20 dropped, `overflow` = 1, `rx_count` = 16. Then drain → exactly 0x10..0x1F.
- FIFO full, then assert `rx_ready` in the same cycle as the 17th byte's push → byte accepted, `overflow` stays 0, order preserved.
- Load `tx_data` = 0x01, then perform a master read → pin shows 0x01 while `bus_rnw` = 1; after the edge `tx_ready` = 1. A second read with nothing loaded → `underrun` = 1, pin still shows 0x01.

Source files
------------

// File: rtl/par8_bus_rx_if.sv
// Byte stream handshakes between par8_bus_rx and its downstream consumer.
// slave = receiver front-end, master = consumer side.
interface par8_bus_rx_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport slave (
        output rx_data, rx_valid, tx_ready,
        input  rx_ready, tx_data, tx_valid
    );

    modport master (
        input  rx_data, rx_valid, tx_ready,
        output rx_ready, tx_data, tx_valid
    );
endinterface

// File: rtl/par8_bus_rx.sv
// RPi 8-bit parallel bus front-end: synchronises the strobe, buffers master writes
// in a FWFT FIFO and returns a consumer-loaded byte on master reads.
module par8_bus_rx #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk_100mhz,
    input  logic             reset_n,
    input  logic             bus_clk,
    input  logic             bus_rnw,
    inout  wire  [7:0]       bus_data,
    par8_bus_rx_if.slave     strm,
    output logic [CNT_W-1:0] rx_count,
    output logic             overflow,
    output logic             underrun
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic             clk_s1_q, clk_s1_d, clk_s2_q, clk_s2_d, clk_prev_q, clk_prev_d;
    logic             rnw_s1_q, rnw_s1_d, rnw_s2_q, rnw_s2_d;
    logic [7:0]       data_s1_q, data_s1_d, data_s2_q, data_s2_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d, und_q, und_d;
    logic [7:0]       tx_hold_q, tx_hold_d;
    logic             tx_loaded_q, tx_loaded_d;
    logic [7:0]       mem_q [DEPTH];

    logic             edge_c, wr_edge_c, rd_edge_c;
    logic             empty_c, full_c, push_c, pop_c, load_c;

    // Strobe edge detection on the synchronised copy of bus_clk
    assign edge_c    = clk_s2_q & ~clk_prev_q;
    assign wr_edge_c = edge_c & ~rnw_s2_q;
    assign rd_edge_c = edge_c &  rnw_s2_q;

    assign empty_c = (wr_ptr_q == rd_ptr_q);
    assign full_c  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop_c   = ~empty_c & strm.rx_ready;
    // A pop in the same cycle frees the slot the push needs
    assign push_c  = wr_edge_c & (~full_c | pop_c);
    assign load_c  = strm.tx_valid & ~tx_loaded_q;

    always_comb begin
        clk_s1_d    = bus_clk;
        clk_s2_d    = clk_s1_q;
        clk_prev_d  = clk_s2_q;
        rnw_s1_d    = bus_rnw;
        rnw_s2_d    = rnw_s1_q;
        data_s1_d   = bus_data;
        data_s2_d   = data_s1_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        und_d       = und_q;
        tx_hold_d   = tx_hold_q;
        tx_loaded_d = tx_loaded_q;

        if (push_c) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
            cnt_d    = cnt_q + CNT_W'(1);
        end else if (wr_edge_c) begin
            ovf_d = 1'b1;
        end
        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end

        if (load_c) begin
            tx_hold_d   = strm.tx_data;
            tx_loaded_d = 1'b1;
        end else if (rd_edge_c) begin
            if (tx_loaded_q) begin
                tx_loaded_d = 1'b0;
            end else begin
                und_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_100mhz) begin
        if (!reset_n) begin
            clk_s1_q    <= 1'b0;
            clk_s2_q    <= 1'b0;
            clk_prev_q  <= 1'b0;
            rnw_s1_q    <= 1'b0;
            rnw_s2_q    <= 1'b0;
            data_s1_q   <= 8'h00;
            data_s2_q   <= 8'h00;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            und_q       <= 1'b0;
            tx_hold_q   <= 8'h00;
            tx_loaded_q <= 1'b0;
        end else begin
            clk_s1_q    <= clk_s1_d;
            clk_s2_q    <= clk_s2_d;
            clk_prev_q  <= clk_prev_d;
            rnw_s1_q    <= rnw_s1_d;
            rnw_s2_q    <= rnw_s2_d;
            data_s1_q   <= data_s1_d;
            data_s2_q   <= data_s2_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            und_q       <= und_d;
            tx_hold_q   <= tx_hold_d;
            tx_loaded_q <= tx_loaded_d;
        end
    end

    // Storage needs no reset; the pointers define what is valid
    always_ff @(posedge clk_100mhz) begin
        if (reset_n && push_c) begin
            mem_q[wr_ptr_q[AW-1:0]] <= data_s2_q;
        end
    end

    assign strm.rx_data  = mem_q[rd_ptr_q[AW-1:0]];
    assign strm.rx_valid = ~empty_c;
    assign strm.tx_ready = ~tx_loaded_q;
    assign rx_count      = cnt_q;
    assign overflow      = ovf_q;
    assign underrun      = und_q;

    // Turnaround follows the raw pin so the master sees data without sync delay
    assign bus_data = bus_rnw ? tx_hold_q : 8'hzz;

endmodule

// File: tb/tb_par8_bus_rx.sv
// Randomised self-checking bench for par8_bus_rx against a byte-level model.
module tb_par8_bus_rx;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned CNT_W = 16;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             bus_clk = 1'b0;
    logic             bus_rnw = 1'b0;
    logic [7:0]       m_data = 8'h00;
    wire  [7:0]       bus_data;
    logic [CNT_W-1:0] rx_count;
    logic             overflow;
    logic             underrun;

    par8_bus_rx_if ifc ();

    par8_bus_rx #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk_100mhz (clk),
        .reset_n    (reset_n),
        .bus_clk    (bus_clk),
        .bus_rnw    (bus_rnw),
        .bus_data   (bus_data),
        .strm       (ifc),
        .rx_count   (rx_count),
        .overflow   (overflow),
        .underrun   (underrun)
    );

    assign bus_data = bus_rnw ? 8'hzz : m_data;

    always #5 clk = ~clk;

    // Byte-level reference model
    logic [7:0] exp_q [$];
    logic [7:0] got_q [$];
    int         m_occ;
    int         m_count;
    bit         m_ovf;
    bit         m_und;
    bit         m_loaded;
    logic [7:0] m_hold;

    int n_cmp = 0;
    int n_mis = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Consumer side: every valid&ready seen mid-cycle is a pop at the next edge
    always @(negedge clk) begin
        if (reset_n && ifc.rx_valid && ifc.rx_ready) got_q.push_back(ifc.rx_data);
    end

    task automatic model_reset();
        exp_q.delete();
        got_q.delete();
        m_occ = 0; m_count = 0; m_ovf = 0; m_und = 0; m_loaded = 0; m_hold = 8'h00;
    endtask

    task automatic do_reset();
        @(posedge clk); #1 reset_n = 1'b0;
        @(posedge clk); #1 reset_n = 1'b1;
        model_reset();
    endtask

    task automatic model_write(input logic [7:0] b, input bit draining);
        if (draining || m_occ < int'(DEPTH)) begin
            exp_q.push_back(b);
            m_count++;
            if (!draining) m_occ++;
        end else begin
            m_ovf = 1;
        end
    endtask

    task automatic write_byte(input logic [7:0] b, input bit meas, input bit rdy_at_push);
        int lat;
        lat = 0;
        @(posedge clk); #1 bus_rnw = 1'b0; m_data = b;
        repeat (3) @(posedge clk);
        #1 bus_clk = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk);
            if (rdy_at_push && i == 2) begin
                #1 ifc.rx_ready = 1'b1;
            end
            @(negedge clk);
            if (lat == 0 && ifc.rx_valid) lat = i;
        end
        if (meas) check_eq("wr_latency_3to4", 32'((lat >= 3) && (lat <= 4)), 32'd1);
        @(posedge clk); #1 bus_clk = 1'b0;
        repeat (3) @(posedge clk);
        model_write(b, meas || rdy_at_push);
    endtask

    task automatic tx_load(input logic [7:0] b);
        @(posedge clk); #1 ifc.tx_data = b; ifc.tx_valid = 1'b1;
        @(posedge clk); #1 ifc.tx_valid = 1'b0;
        if (!m_loaded) begin
            m_hold = b;
            m_loaded = 1;
        end
        @(negedge clk);
        check_eq("tx_ready_loaded", 32'(ifc.tx_ready), 32'd0);
    endtask

    task automatic master_read();
        @(posedge clk); #1 bus_rnw = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("pin_before_edge", 32'(bus_data), 32'(m_hold));
        @(posedge clk); #1 bus_clk = 1'b1;
        repeat (5) @(posedge clk);
        #1 bus_clk = 1'b0;
        if (m_loaded) m_loaded = 0;
        else          m_und = 1;
        @(negedge clk);
        check_eq("pin_after_edge", 32'(bus_data), 32'(m_hold));
        check_eq("tx_ready_after_rd", 32'(ifc.tx_ready), 32'd1);
        check_eq("underrun", 32'(underrun), 32'(m_und));
        repeat (3) @(posedge clk);
        #1 bus_rnw = 1'b0;
    endtask

    task automatic drain_check(input string tag);
        int k;
        int n;
        k = 0;
        @(posedge clk); #1 ifc.rx_ready = 1'b1;
        do begin
            @(negedge clk);
            k++;
        end while (ifc.rx_valid && k < 64);
        ifc.rx_ready = 1'b0;
        check_eq({tag, "_drain_done"}, 32'(ifc.rx_valid), 32'd0);
        check_eq({tag, "_len"}, 32'(got_q.size()), 32'(exp_q.size()));
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) check_eq({tag, "_byte"}, 32'(got_q[i]), 32'(exp_q[i]));
        got_q.delete();
        exp_q.delete();
        m_occ = 0;
        check_eq({tag, "_count"}, 32'(rx_count), 32'(m_count[CNT_W-1:0]));
        check_eq({tag, "_overflow"}, 32'(overflow), 32'(m_ovf));
        check_eq({tag, "_underrun"}, 32'(underrun), 32'(m_und));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        ifc.rx_ready = 1'b0;
        ifc.tx_valid = 1'b0;
        ifc.tx_data  = 8'h00;
        model_reset();
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        check_eq("rst_rx_valid", 32'(ifc.rx_valid), 32'd0);
        check_eq("rst_count", 32'(rx_count), 32'd0);
        check_eq("rst_overflow", 32'(overflow), 32'd0);
        check_eq("rst_underrun", 32'(underrun), 32'd0);
        check_eq("rst_tx_ready", 32'(ifc.tx_ready), 32'd1);

        // Reset mid-stream discards FIFO contents and a loaded response
        tx_load(8'hA5);
        for (int i = 0; i < 5; i++) write_byte(8'(8'h30 + i), 1'b0, 1'b0);
        check_eq("mid_count", 32'(rx_count), 32'd5);
        check_eq("mid_rx_valid", 32'(ifc.rx_valid), 32'd1);
        do_reset();
        @(negedge clk);
        check_eq("mid_rst_rx_valid", 32'(ifc.rx_valid), 32'd0);
        check_eq("mid_rst_count", 32'(rx_count), 32'd0);
        check_eq("mid_rst_overflow", 32'(overflow), 32'd0);
        check_eq("mid_rst_underrun", 32'(underrun), 32'd0);
        check_eq("mid_rst_tx_ready", 32'(ifc.tx_ready), 32'd1);

        // Streaming 0x00..0xFF with a consumer that is always ready
        ifc.rx_ready = 1'b1;
        for (int i = 0; i < 256; i++) write_byte(8'(i), 1'b1, 1'b0);
        drain_check("stream");
        check_eq("stream_count_256", 32'(rx_count), 32'd256);

        // Overflow: 17 bytes into a 16-deep FIFO with a stalled consumer
        do_reset();
        for (int i = 0; i < 17; i++) write_byte(8'(8'h10 + i), 1'b0, 1'b0);
        check_eq("ovf_count", 32'(rx_count), 32'd16);
        check_eq("ovf_flag", 32'(overflow), 32'd1);
        drain_check("ovf");

        // Full FIFO with a pop coinciding with the 17th push
        do_reset();
        for (int i = 0; i < 16; i++) write_byte(8'(8'h40 + i), 1'b0, 1'b0);
        write_byte(8'h50, 1'b0, 1'b1);
        check_eq("coinc_overflow", 32'(overflow), 32'd0);
        drain_check("coinc");

        // Response path: loaded read then an underrunning read
        do_reset();
        tx_load(8'h01);
        master_read();
        master_read();

        // Randomised mix of writes, loads and reads
        do_reset();
        for (int r = 0; r < 8; r++) begin
            int n;
            n = $urandom_range(4, 20);
            for (int j = 0; j < n; j++) begin
                int op;
                op = $urandom_range(0, 7);
                if (op == 0) tx_load(8'($urandom));
                else if (op == 1) master_read();
                write_byte(8'($urandom), 1'b0, 1'b0);
            end
            drain_check("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
